ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-master arbiter and sequencer for the single-port synchronous `ram` block (one access per clock, read data valid one cycle after the address, word-addressed, whole-word write enable). It shares the RAM between the instruction-fetch master (m0, read-only) and the load/store master (m1, read/write with byte enables). Partial-word stores are turned into a two-cycle read-modify-write. It sits between the core's fetch and LSU ports and the `ram` instance.

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of 8
- ADDR_WIDTH, 12, word-address width; the RAM holds 2^ADDR_WIDTH words
- NUM_BYTES, DATA_WIDTH/8, derived; number of byte enables
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  asynchronous reset, active low
- i_m0_req  in  1  fetch request; held until granted
- i_m0_addr  in  ADDR_WIDTH  fetch word address
- o_m0_gnt  out  1  request accepted this cycle
- o_m0_rvalid  out  1  o_m0_rdata valid; one-cycle pulse
- o_m0_rdata  out  DATA_WIDTH  read data
- i_m1_req  in  1  data request; held with all m1 inputs stable until granted
- i_m1_we  in  1  1 = store, 0 = load
- i_m1_be  in  NUM_BYTES  store byte enables; ignored for loads
- i_m1_addr  in  ADDR_WIDTH  data word address
- i_m1_wdata  in  DATA_WIDTH  store data
- o_m1_gnt  out  1  request accepted this cycle
- o_m1_rvalid  out  1  load data valid; one-cycle pulse
- o_m1_rdata  out  DATA_WIDTH  load data
- o_ram_we  out  1  to ram i_we
- o_ram_addr  out  ADDR_WIDTH  to ram i_addr
- o_ram_wrdata  out  DATA_WIDTH  to ram i_wrdata
- i_ram_rdata  in  DATA_WIDTH  from ram o_rdata

## Operation
- States: IDLE and RMW_WR. Register last_gnt (0 = m0, 1 = m1) is reset to 0, so m1 wins the first tie.
- IDLE, arbitration:
  - With one requester, that master wins.
  - With both requesting, the master not equal to last_gnt wins (round-robin).
  - With no requester, all RAM outputs are 0.
- Winner m0, or m1 with a load: drive o_ram_addr and o_ram_we=0, and assert the winner's gnt in the same cycle. Set last_gnt to the winner. Set that port's rd_pending flop.
- Winner m1 with a store and i_m1_be all ones: assert o_ram_we=1 and o_m1_gnt in the same cycle. No rvalid is produced.
- Winner m1 with a store and i_m1_be == 0: assert o_m1_gnt with o_ram_we=0. The RAM is untouched and no rvalid is produced.
- Winner m1 with a store and partial i_m1_be:
  - In IDLE: issue a read of i_m1_addr with no gnt, then go to RMW_WR. This read does not set rd_pending.
  - In RMW_WR:
    - o_ram_addr = i_m1_addr and o_ram_we = 1.
    - o_ram_wrdata byte k = i_m1_be[k] ? i_m1_wdata byte k : i_ram_rdata byte k.
    - Assert o_m1_gnt, set last_gnt = 1, and return to IDLE.
  - m0 is not granted during RMW_WR.
- If i_m1_req drops during RMW_WR (protocol violation): no write and no gnt; return to IDLE.
- o_mX_rvalid = rd_pending[X], registered. o_mX_rdata = i_ram_rdata, passed through combinationally.
- The address is a word address; no alignment or range checks.

## Timing
- Reset: o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_ram_we = 0; o_ram_addr = 0; o_ram_wrdata = 0; state = IDLE; last_gnt = 0; rd_pending = 0.
- gnt is combinational from req, state and last_gnt. A request is accepted on the edge where req and gnt are both 1.
- Load or fetch latency: gnt in cycle N, rvalid and data in cycle N+1.
- Full-word or zero-byte store: 1 cycle. Partial store: 2 cycles, with gnt in the second.
- Throughput is one access per cycle; back-to-back grants are allowed.
- A load granted in cycle N+1 after a store to the same address in cycle N returns the new data.
- Reset asserted in RMW_WR: o_ram_we drops immediately and no write occurs. In-flight rvalid is cancelled.
- A reset release with requests pending arbitrates on the first edge, with m1 winning a tie.

## Test plan
- Reset: hold i_rst_n=0 with both req=1 -> all gnt, rvalid and o_ram_we = 0. After release, the first tie grants m1.
- Single fetch: m0 reads addr 5 after the RAM was preloaded with word 5 = 0x0000000A -> o_m0_gnt in cycle N, o_m0_rvalid=1 and o_m0_rdata=0x0000000A in N+1, o_m1_rvalid=0.
- Contention: m0 and m1 both request loads continuously -> grants alternate m1, m0, m1, m0. Each rvalid pulses on its own port one cycle after its gnt with the correct data.
- Full store then load: m1 writes 0xDEADBEEF with be=4'hF to addr 0x10, then loads addr 0x10 -> one-cycle store; the load returns 0xDEADBEEF.
- Partial store: with addr 0x10 = 0xDEADBEEF, m1 stores 0x000000AA with be=4'b0001 -> gnt in the second cycle, a later load returns 0xDEADBEAA, and a simultaneous m0 req waits the 2 cycles.
- Edge cases:
  - A be=0 store is granted in 1 cycle and the memory is unchanged.
  - Asserting reset during RMW_WR leaves the target word unchanged.
  - Sweep all 4096 addresses with alternating m0/m1 traffic and no data mismatch.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two core masters (fetch m0, load/store m1) and the
// single-port RAM, as seen by the arbiter (slave) and by its users (master).
interface ram_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    // Fetch master (read-only)
    logic                  i_m0_req;
    logic [ADDR_WIDTH-1:0] i_m0_addr;
    logic                  o_m0_gnt;
    logic                  o_m0_rvalid;
    logic [DATA_WIDTH-1:0] o_m0_rdata;

    // Load/store master
    logic                  i_m1_req;
    logic                  i_m1_we;
    logic [NUM_BYTES-1:0]  i_m1_be;
    logic [ADDR_WIDTH-1:0] i_m1_addr;
    logic [DATA_WIDTH-1:0] i_m1_wdata;
    logic                  o_m1_gnt;
    logic                  o_m1_rvalid;
    logic [DATA_WIDTH-1:0] o_m1_rdata;

    // RAM side
    logic                  o_ram_we;
    logic [ADDR_WIDTH-1:0] o_ram_addr;
    logic [DATA_WIDTH-1:0] o_ram_wrdata;
    logic [DATA_WIDTH-1:0] i_ram_rdata;

    // Arbiter view
    modport slave (
        input  i_m0_req, i_m0_addr,
        output o_m0_gnt, o_m0_rvalid, o_m0_rdata,
        input  i_m1_req, i_m1_we, i_m1_be, i_m1_addr, i_m1_wdata,
        output o_m1_gnt, o_m1_rvalid, o_m1_rdata,
        output o_ram_we, o_ram_addr, o_ram_wrdata,
        input  i_ram_rdata
    );

    // Core/RAM view
    modport master (
        output i_m0_req, i_m0_addr,
        input  o_m0_gnt, o_m0_rvalid, o_m0_rdata,
        output i_m1_req, i_m1_we, i_m1_be, i_m1_addr, i_m1_wdata,
        input  o_m1_gnt, o_m1_rvalid, o_m1_rdata,
        input  o_ram_we, o_ram_addr, o_ram_wrdata,
        output i_ram_rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter for a single-port synchronous RAM.
// m0 fetches, m1 loads/stores; partial-word stores become a read followed
// by a merged full-word write. Grants and RAM controls are combinational so
// an access is issued in the same cycle it is granted.
module ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    ram_arbiter_if.slave  bus
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  last_gnt_q, last_gnt_d;     // 0 = m0, 1 = m1
    logic [1:0]            rd_pending_q, rd_pending_d; // [0] = m0, [1] = m1

    logic                  m1_wins_s;
    logic                  be_full_s;
    logic                  be_none_s;
    logic                  m0_gnt_s;
    logic                  m1_gnt_s;
    logic                  ram_we_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic [DATA_WIDTH-1:0] ram_wrdata_s;

    // Byte-lane merge: enabled lanes from the store data, the rest from the
    // word just read back from the RAM.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [NUM_BYTES-1:0]  be
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            merged[k*8 +: 8] = be[k] ? new_word[k*8 +: 8] : old_word[k*8 +: 8];
        end
        return merged;
    endfunction

    // m1 takes a tie only when m0 had the previous grant.
    assign m1_wins_s = bus.i_m1_req & (~bus.i_m0_req | ~last_gnt_q);
    assign be_full_s = &bus.i_m1_be;
    assign be_none_s = ~|bus.i_m1_be;

    // Arbitration, RAM command generation and next-state logic.
    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        rd_pending_d = 2'b00;
        m0_gnt_s     = 1'b0;
        m1_gnt_s     = 1'b0;
        ram_we_s     = 1'b0;
        ram_addr_s   = '0;
        ram_wrdata_s = '0;

        if (!i_rst_n) begin
            // Keep the RAM quiet while reset is held, even mid read-modify-write.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m1_wins_s) begin
                        ram_addr_s = bus.i_m1_addr;
                        if (!bus.i_m1_we) begin
                            m1_gnt_s        = 1'b1;
                            last_gnt_d      = 1'b1;
                            rd_pending_d[1] = 1'b1;
                        end else if (be_full_s) begin
                            m1_gnt_s     = 1'b1;
                            ram_we_s     = 1'b1;
                            ram_wrdata_s = bus.i_m1_wdata;
                            last_gnt_d   = 1'b1;
                        end else if (be_none_s) begin
                            // Nothing to write: accept without touching the RAM.
                            m1_gnt_s   = 1'b1;
                            last_gnt_d = 1'b1;
                        end else begin
                            // Partial store: read the old word first, no grant yet.
                            state_d = ST_RMW_WR;
                        end
                    end else if (bus.i_m0_req) begin
                        m0_gnt_s        = 1'b1;
                        ram_addr_s      = bus.i_m0_addr;
                        last_gnt_d      = 1'b0;
                        rd_pending_d[0] = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_RMW_WR: begin
                    if (bus.i_m1_req) begin
                        m1_gnt_s     = 1'b1;
                        ram_we_s     = 1'b1;
                        ram_addr_s   = bus.i_m1_addr;
                        ram_wrdata_s = merge_bytes(bus.i_m1_wdata, bus.i_ram_rdata,
                                                   bus.i_m1_be);
                        last_gnt_d   = 1'b1;
                    end else begin
                        // Request withdrawn mid-sequence: abandon the write.
                        m1_gnt_s = 1'b0;
                    end
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, round-robin pointer and read-pending flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            last_gnt_q   <= 1'b0;
            rd_pending_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    assign bus.o_m0_gnt     = m0_gnt_s;
    assign bus.o_m1_gnt     = m1_gnt_s;
    assign bus.o_m0_rvalid  = rd_pending_q[0];
    assign bus.o_m1_rvalid  = rd_pending_q[1];
    assign bus.o_m0_rdata   = bus.i_ram_rdata;
    assign bus.o_m1_rdata   = bus.i_ram_rdata;
    assign bus.o_ram_we     = ram_we_s;
    assign bus.o_ram_addr   = ram_addr_s;
    assign bus.o_ram_wrdata = ram_wrdata_s;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM.
module tb_ram_arbiter;
    localparam int DW = 32;
    localparam int AW = 12;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    // Behavioural RAM: write-enable, read data one cycle after the address.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (bus.o_ram_we) mem[bus.o_ram_addr] <= bus.o_ram_wrdata;
        ram_q <= mem[bus.o_ram_addr];
    end
    assign bus.i_ram_rdata = ram_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_all();
        bus.i_m0_req   = 1'b0;
        bus.i_m0_addr  = '0;
        bus.i_m1_req   = 1'b0;
        bus.i_m1_we    = 1'b0;
        bus.i_m1_be    = 4'h0;
        bus.i_m1_addr  = '0;
        bus.i_m1_wdata = '0;
    endtask

    task automatic m1_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        bus.i_m1_req   = 1'b1;
        bus.i_m1_we    = 1'b1;
        bus.i_m1_be    = be;
        bus.i_m1_addr  = a;
        bus.i_m1_wdata = d;
    endtask

    task automatic m1_load(input logic [AW-1:0] a);
        bus.i_m1_req   = 1'b1;
        bus.i_m1_we    = 1'b0;
        bus.i_m1_be    = 4'h0;
        bus.i_m1_addr  = a;
        bus.i_m1_wdata = '0;
    endtask

    task automatic m0_fetch(input logic [AW-1:0] a);
        bus.i_m0_req  = 1'b1;
        bus.i_m0_addr = a;
    endtask

    function automatic logic [31:0] pat(input int a);
        return 32'h5A5A0000 ^ (32'(a) * 32'h00010003);
    endfunction

    localparam logic [31:0] D20 = 32'h11112222;
    localparam logic [31:0] D21 = 32'h33334444;

    initial begin
        n_cmp = 0;
        n_mis = 0;
        idle_all();

        // Reset held with both masters requesting
        rst_n = 1'b0;
        m0_fetch(12'd1);
        m1_load(12'd2);
        repeat (3) tick();
        chk("rst_m0_gnt",    32'(bus.o_m0_gnt),     32'd0);
        chk("rst_m1_gnt",    32'(bus.o_m1_gnt),     32'd0);
        chk("rst_m0_rvalid", 32'(bus.o_m0_rvalid),  32'd0);
        chk("rst_m1_rvalid", 32'(bus.o_m1_rvalid),  32'd0);
        chk("rst_ram_we",    32'(bus.o_ram_we),     32'd0);
        chk("rst_ram_addr",  32'(bus.o_ram_addr),   32'd0);
        chk("rst_ram_wdata", bus.o_ram_wrdata,      32'd0);

        // Release: first tie goes to m1
        rst_n = 1'b1;
        settle();
        chk("tie1_m1_gnt",  32'(bus.o_m1_gnt),   32'd1);
        chk("tie1_m0_gnt",  32'(bus.o_m0_gnt),   32'd0);
        chk("tie1_addr",    32'(bus.o_ram_addr), 32'd2);
        tick();
        bus.i_m1_req = 1'b0;
        settle();
        chk("tie2_m0_gnt",  32'(bus.o_m0_gnt),    32'd1);
        chk("tie2_m1_rv",   32'(bus.o_m1_rvalid), 32'd1);
        chk("tie2_m0_rv",   32'(bus.o_m0_rvalid), 32'd0);
        tick();
        idle_all();
        settle();
        chk("tie3_m0_rv",   32'(bus.o_m0_rvalid), 32'd1);
        tick();

        // Preload words through full stores
        m1_store(12'd5, 32'h0000000A, 4'hF);
        settle();
        chk("st5_gnt",   32'(bus.o_m1_gnt),   32'd1);
        chk("st5_we",    32'(bus.o_ram_we),   32'd1);
        chk("st5_wdata", bus.o_ram_wrdata,    32'h0000000A);
        tick();
        m1_store(12'h020, D20, 4'hF);
        tick();
        m1_store(12'h021, D21, 4'hF);
        tick();

        // Single fetch of word 5
        idle_all();
        m0_fetch(12'd5);
        settle();
        chk("f5_gnt", 32'(bus.o_m0_gnt), 32'd1);
        chk("f5_we",  32'(bus.o_ram_we), 32'd0);
        tick();
        idle_all();
        settle();
        chk("f5_rv0",   32'(bus.o_m0_rvalid), 32'd1);
        chk("f5_rdata", bus.o_m0_rdata,       32'h0000000A);
        chk("f5_rv1",   32'(bus.o_m1_rvalid), 32'd0);

        // Contention: both loading continuously, m1 first
        m0_fetch(12'h020);
        m1_load(12'h021);
        settle();
        chk("c1_m1_gnt", 32'(bus.o_m1_gnt), 32'd1);
        chk("c1_m0_gnt", 32'(bus.o_m0_gnt), 32'd0);
        tick();
        chk("c2_m0_gnt", 32'(bus.o_m0_gnt),    32'd1);
        chk("c2_m1_gnt", 32'(bus.o_m1_gnt),    32'd0);
        chk("c2_m1_rv",  32'(bus.o_m1_rvalid), 32'd1);
        chk("c2_rdata",  bus.o_m1_rdata,       D21);
        tick();
        chk("c3_m1_gnt", 32'(bus.o_m1_gnt),    32'd1);
        chk("c3_m0_rv",  32'(bus.o_m0_rvalid), 32'd1);
        chk("c3_m1_rv",  32'(bus.o_m1_rvalid), 32'd0);
        chk("c3_rdata",  bus.o_m0_rdata,       D20);
        tick();
        chk("c4_m0_gnt", 32'(bus.o_m0_gnt),    32'd1);
        chk("c4_m1_rv",  32'(bus.o_m1_rvalid), 32'd1);
        chk("c4_rdata",  bus.o_m1_rdata,       D21);
        tick();
        idle_all();
        settle();
        chk("c5_m0_rv",  32'(bus.o_m0_rvalid), 32'd1);
        chk("c5_rdata",  bus.o_m0_rdata,       D20);

        // Full store then back-to-back load of the same word
        m1_store(12'h010, 32'hDEADBEEF, 4'hF);
        settle();
        chk("fs_gnt", 32'(bus.o_m1_gnt), 32'd1);
        chk("fs_we",  32'(bus.o_ram_we), 32'd1);
        tick();
        m1_load(12'h010);
        settle();
        chk("fl_gnt", 32'(bus.o_m1_gnt), 32'd1);
        chk("fl_we",  32'(bus.o_ram_we), 32'd0);
        tick();
        idle_all();
        settle();
        chk("fl_rv",    32'(bus.o_m1_rvalid), 32'd1);
        chk("fl_rdata", bus.o_m1_rdata,       32'hDEADBEEF);

        // Move the pointer to m0 so m1 wins the next tie
        m0_fetch(12'd5);
        tick();
        idle_all();

        // Partial store with m0 contending
        m0_fetch(12'd5);
        m1_store(12'h010, 32'h000000AA, 4'b0001);
        settle();
        chk("ps1_m1_gnt", 32'(bus.o_m1_gnt),   32'd0);
        chk("ps1_m0_gnt", 32'(bus.o_m0_gnt),   32'd0);
        chk("ps1_we",     32'(bus.o_ram_we),   32'd0);
        chk("ps1_addr",   32'(bus.o_ram_addr), 32'h010);
        tick();
        chk("ps2_m1_gnt", 32'(bus.o_m1_gnt),    32'd1);
        chk("ps2_m0_gnt", 32'(bus.o_m0_gnt),    32'd0);
        chk("ps2_we",     32'(bus.o_ram_we),    32'd1);
        chk("ps2_wdata",  bus.o_ram_wrdata,     32'hDEADBEAA);
        chk("ps2_m1_rv",  32'(bus.o_m1_rvalid), 32'd0);
        tick();
        bus.i_m1_req = 1'b0;
        settle();
        chk("ps3_m0_gnt", 32'(bus.o_m0_gnt), 32'd1);
        tick();
        bus.i_m0_req = 1'b0;
        m1_load(12'h010);
        settle();
        chk("ps4_m0_rv",    32'(bus.o_m0_rvalid), 32'd1);
        chk("ps4_rdata",    bus.o_m0_rdata,       32'h0000000A);
        chk("ps4_m1_gnt",   32'(bus.o_m1_gnt),    32'd1);
        tick();
        idle_all();
        settle();
        chk("ps5_rv",    32'(bus.o_m1_rvalid), 32'd1);
        chk("ps5_rdata", bus.o_m1_rdata,       32'hDEADBEAA);

        // Zero-byte store: granted at once, memory untouched
        m1_store(12'h010, 32'hFFFFFFFF, 4'h0);
        settle();
        chk("z_gnt", 32'(bus.o_m1_gnt), 32'd1);
        chk("z_we",  32'(bus.o_ram_we), 32'd0);
        tick();
        m1_load(12'h010);
        tick();
        idle_all();
        settle();
        chk("z_rdata", bus.o_m1_rdata, 32'hDEADBEAA);

        // Reset asserted during the write half of a partial store
        m1_store(12'h010, 32'h00001100, 4'b0010);
        tick();
        chk("rr_we_before", 32'(bus.o_ram_we), 32'd1);
        rst_n = 1'b0;
        settle();
        chk("rr_we_rst",  32'(bus.o_ram_we), 32'd0);
        chk("rr_gnt_rst", 32'(bus.o_m1_gnt), 32'd0);
        idle_all();
        tick();
        rst_n = 1'b1;
        tick();
        m1_load(12'h010);
        tick();
        idle_all();
        settle();
        chk("rr_rdata", bus.o_m1_rdata, 32'hDEADBEAA);

        // Reset cancels an in-flight rvalid
        m0_fetch(12'd5);
        tick();
        idle_all();
        settle();
        chk("rc_rv_before", 32'(bus.o_m0_rvalid), 32'd1);
        rst_n = 1'b0;
        settle();
        chk("rc_rv_rst", 32'(bus.o_m0_rvalid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fill every address, then read all back alternating masters
        for (int a = 0; a < (1 << AW); a++) begin
            m1_store(AW'(a), pat(a), 4'hF);
            tick();
        end
        idle_all();
        for (int a = 0; a < (1 << AW); a++) begin
            idle_all();
            if (a % 2 == 0) m0_fetch(AW'(a));
            else            m1_load(AW'(a));
            settle();
            if (a % 2 == 0) chk("sw_gnt0", 32'(bus.o_m0_gnt), 32'd1);
            else            chk("sw_gnt1", 32'(bus.o_m1_gnt), 32'd1);
            if (a > 0) begin
                if (a % 2 == 0) chk("sw_rv1", 32'(bus.o_m1_rvalid), 32'd1);
                else            chk("sw_rv0", 32'(bus.o_m0_rvalid), 32'd1);
                chk("sw_data", bus.o_m0_rdata, pat(a - 1));
            end
            tick();
        end
        idle_all();
        settle();
        chk("sw_last_rv", 32'(bus.o_m1_rvalid), 32'd1);
        chk("sw_last",    bus.o_m1_rdata,       pat((1 << AW) - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
